// File: rtl/fpu_pkg.sv
// Shared types and default latencies for the FPU issue scheduler and its writeback ring.
package fpu_pkg;

    typedef enum logic [1:0] {
        U_ADD  = 2'd0,
        U_MUL  = 2'd1,
        U_HALF = 2'd2,
        U_DIV  = 2'd3
    } fpu_unit_t;

    localparam int unsigned LatAddDef  = 3;
    localparam int unsigned LatMulDef  = 2;
    localparam int unsigned LatHalfDef = 1;

    // Ring slots carry the widest tag any instance may use; instances use the low bits.
    localparam int unsigned TagWMax = 16;

    typedef struct packed {
        logic                valid;
        fpu_unit_t           unit;
        logic [TagWMax-1:0]  tag;
    } res_slot_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fpu_wb_ring.sv
// Writeback reservation ring: slot k holds the result due on the writeback port k cycles
// from now, with a per-slot occupancy vector and the entry that loads writeback next edge.
module fpu_wb_ring
    import fpu_pkg::*;
#(
    parameter int unsigned Depth = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [Depth-1:0] ins_oh_i,
    input  res_slot_t        ins_slot_i,
    output logic [Depth-1:0] busy_o,
    output res_slot_t        head_o
);

    res_slot_t slot_q [Depth];
    res_slot_t slot_d [Depth];
    res_slot_t view   [Depth];

    always_comb begin
        for (int k = 0; k < int'(Depth); k++) begin
            view[k]   = ins_oh_i[k] ? ins_slot_i : slot_q[k];
            busy_o[k] = slot_q[k].valid;
            slot_d[k] = '0;
        end
        for (int k = 0; k + 1 < int'(Depth); k++) begin
            slot_d[k] = view[k+1];
        end
        head_o = view[0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < int'(Depth); k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(Depth); k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

endmodule

// File: rtl/fpu_sched.sv
// FPU issue scheduler: fires unit start strobes and reserves the shared writeback port.
// Define FPU_SCHED_FHALF_EN to send U_HALF to the dedicated fhalf unit instead of fmul*0.5.
module fpu_sched
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned LAT_ADD  = LatAddDef,
    parameter int unsigned LAT_MUL  = LatMulDef,
    parameter int unsigned LAT_HALF = LatHalfDef
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  fpu_unit_t        req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             add_go,
    output logic             mul_go,
    output logic             half_go,
    output logic             div_go,
    output logic             mul_half,
    input  logic             div_done,
    output logic             div_ack,
    output logic             wb_valid,
    output fpu_unit_t        wb_sel,
    output logic [TAG_W-1:0] wb_tag
);

    localparam int unsigned MaxLat = max3(LAT_ADD, LAT_MUL, LAT_HALF);

    typedef enum logic [0:0] {StIdle, StRun} div_state_e;

    div_state_e       div_state_q, div_state_d;
    logic [TAG_W-1:0] div_tag_q, div_tag_d;
    logic             wb_valid_q, wb_valid_d;
    fpu_unit_t        wb_sel_q, wb_sel_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;

    fpu_unit_t         eff_unit;
    int unsigned       eff_lat;
    logic              is_half;
    logic [MaxLat-1:0] lat_oh, busy, ins_oh;
    res_slot_t         ins_slot, head;
    logic              claim, slot_free, accept;
    logic              unused_head_tag;

    always_comb begin
        eff_unit = req_op;
        eff_lat  = LAT_ADD;
        is_half  = 1'b0;
        unique case (req_op)
            U_ADD:  eff_lat = LAT_ADD;
            U_MUL:  eff_lat = LAT_MUL;
            U_HALF: begin
`ifdef FPU_SCHED_FHALF_EN
                eff_lat = LAT_HALF;
`else
                eff_unit = U_MUL;
                eff_lat  = LAT_MUL;
                is_half  = 1'b1;
`endif
            end
            U_DIV:  eff_lat = LAT_ADD;
        endcase
    end

    // A pending divide result wins the next writeback over a same-cycle single-cycle issue.
    always_comb begin
        lat_oh    = MaxLat'(1) << (eff_lat - 1);
        claim     = rstn && (div_state_q == StRun) && div_done && !busy[0];
        slot_free = ~|(busy & lat_oh) && !((eff_lat == 1) && claim);
        req_ready = rstn && ((req_op == U_DIV) ? (div_state_q == StIdle) : slot_free);
        accept    = req_valid && req_ready;

        add_go   = accept && (eff_unit == U_ADD);
        mul_go   = accept && (eff_unit == U_MUL);
        div_go   = accept && (eff_unit == U_DIV);
        mul_half = mul_go && is_half;
`ifdef FPU_SCHED_FHALF_EN
        half_go  = accept && (eff_unit == U_HALF);
`else
        half_go  = 1'b0;
`endif
        div_ack  = claim;

        ins_oh         = (accept && (eff_unit != U_DIV)) ? lat_oh : '0;
        ins_slot.valid = 1'b1;
        ins_slot.unit  = eff_unit;
        ins_slot.tag   = TagWMax'(req_tag);
    end

    fpu_wb_ring #(
        .Depth (MaxLat)
    ) u_ring (
        .clk        (clk),
        .rstn       (rstn),
        .ins_oh_i   (ins_oh),
        .ins_slot_i (ins_slot),
        .busy_o     (busy),
        .head_o     (head)
    );

    assign unused_head_tag = ^head.tag;

    always_comb begin
        div_state_d = div_state_q;
        div_tag_d   = div_tag_q;
        unique case (div_state_q)
            StIdle: begin
                if (accept && (req_op == U_DIV)) begin
                    div_state_d = StRun;
                    div_tag_d   = req_tag;
                end
            end
            StRun: begin
                if (claim) begin
                    div_state_d = StIdle;
                end
            end
        endcase

        if (claim) begin
            wb_valid_d = 1'b1;
            wb_sel_d   = U_DIV;
            wb_tag_d   = div_tag_q;
        end else begin
            wb_valid_d = head.valid;
            wb_sel_d   = head.unit;
            wb_tag_d   = head.tag[TAG_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_state_q <= StIdle;
            div_tag_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_sel_q    <= U_ADD;
            wb_tag_q    <= '0;
        end else begin
            div_state_q <= div_state_d;
            div_tag_q   <= div_tag_d;
            wb_valid_q  <= wb_valid_d;
            wb_sel_q    <= wb_sel_d;
            wb_tag_q    <= wb_tag_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_sel   = wb_sel_q;
    assign wb_tag   = wb_tag_q;

endmodule

// File: tb/tb_fpu_sched.sv
// Bench for fpu_sched: directed scenarios with literal expectations, then random traffic
// checked every cycle against a writeback-calendar model.
module tb_fpu_sched;
    import fpu_pkg::*;

    localparam int unsigned TW = 6;
    localparam int unsigned LA = 3;
    localparam int unsigned LM = 2;
    localparam int unsigned LH = 1;
    localparam int CalN = 16;

`ifdef FPU_SCHED_FHALF_EN
    localparam int        ColGap  = 2;
    localparam fpu_unit_t ColOp   = U_HALF;
    localparam fpu_unit_t PriOp   = U_HALF;
    localparam bit        PriRdy  = 1'b0;
    localparam logic [2:0] HalfGo = 3'b001;
    localparam int        HalfLat = 1;
    localparam fpu_unit_t HalfSel = U_HALF;
`else
    localparam int        ColGap  = 1;
    localparam fpu_unit_t ColOp   = U_MUL;
    localparam fpu_unit_t PriOp   = U_ADD;
    localparam bit        PriRdy  = 1'b1;
    localparam logic [2:0] HalfGo = 3'b110;
    localparam int        HalfLat = 2;
    localparam fpu_unit_t HalfSel = U_MUL;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    fpu_unit_t     req_op;
    logic [TW-1:0] req_tag;
    logic          add_go, mul_go, half_go, div_go, mul_half;
    logic          div_done;
    logic          div_ack;
    logic          wb_valid;
    fpu_unit_t     wb_sel;
    logic [TW-1:0] wb_tag;

    always #5 clk = ~clk;

    fpu_sched #(
        .TAG_W    (TW),
        .LAT_ADD  (LA),
        .LAT_MUL  (LM),
        .LAT_HALF (LH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .add_go    (add_go),
        .mul_go    (mul_go),
        .half_go   (half_go),
        .div_go    (div_go),
        .mul_half  (mul_half),
        .div_done  (div_done),
        .div_ack   (div_ack),
        .wb_valid  (wb_valid),
        .wb_sel    (wb_sel),
        .wb_tag    (wb_tag)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit known   = 1'b0;

    // Calendar of expected writebacks, indexed by absolute cycle modulo CalN.
    bit            cal_v [CalN];
    fpu_unit_t     cal_u [CalN];
    logic [TW-1:0] cal_t [CalN];
    bit            m_div_busy = 1'b0;
    logic [TW-1:0] m_div_tag  = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] wbv();
        return 32'({wb_valid, wb_sel, wb_tag});
    endfunction

    function automatic void map_op(input fpu_unit_t op, output fpu_unit_t u, output int lat,
                                   output bit half);
        half = 1'b0;
        u    = op;
        lat  = 1;
        case (op)
            U_ADD:  lat = LA;
            U_MUL:  lat = LM;
            U_HALF: begin
`ifdef FPU_SCHED_FHALF_EN
                lat = LH;
`else
                u    = U_MUL;
                lat  = LM;
                half = 1'b1;
`endif
            end
            default: lat = 1;
        endcase
    endfunction

    always @(negedge clk) begin
        fpu_unit_t u;
        int        lat;
        bit        half, claim, rdy, acc;
        logic [6:0] exp_c;
        int        i0;
        i0 = cyc % CalN;
        if (known) begin
            chk("wb", wbv(), 32'({cal_v[i0], cal_u[i0], cal_t[i0]}));
        end
        if (!rstn) begin
            chk("comb_in_reset",
                32'({req_ready, add_go, mul_go, half_go, div_go, mul_half, div_ack}), 32'd0);
            for (int i = 0; i < CalN; i++) begin
                cal_v[i] = 1'b0;
                cal_u[i] = U_ADD;
                cal_t[i] = '0;
            end
            m_div_busy = 1'b0;
            known      = 1'b1;
        end else begin
            map_op(req_op, u, lat, half);
            claim = m_div_busy && div_done && !cal_v[(cyc + 1) % CalN];
            if (req_op == U_DIV) rdy = !m_div_busy;
            else rdy = !cal_v[(cyc + lat) % CalN] && !((lat == 1) && claim);
            acc   = req_valid && rdy;
            exp_c = {rdy, acc && (u == U_ADD), acc && (u == U_MUL), acc && (u == U_HALF),
                     acc && (u == U_DIV), acc && half, claim};
            chk("comb", 32'({req_ready, add_go, mul_go, half_go, div_go, mul_half, div_ack}),
                32'(exp_c));
            cal_v[i0] = 1'b0;
            cal_u[i0] = U_ADD;
            cal_t[i0] = '0;
            if (claim) begin
                cal_v[(cyc + 1) % CalN] = 1'b1;
                cal_u[(cyc + 1) % CalN] = U_DIV;
                cal_t[(cyc + 1) % CalN] = m_div_tag;
                m_div_busy = 1'b0;
            end
            if (acc && (u == U_DIV)) begin
                m_div_busy = 1'b1;
                m_div_tag  = req_tag;
            end else if (acc) begin
                cal_v[(cyc + lat) % CalN] = 1'b1;
                cal_u[(cyc + lat) % CalN] = u;
                cal_t[(cyc + lat) % CalN] = req_tag;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input fpu_unit_t op, input logic [TW-1:0] tag);
        req_valid = v;
        req_op    = op;
        req_tag   = tag;
    endtask

    task automatic idle(input int n);
        drive(1'b0, U_ADD, '0);
        repeat (n) tick();
    endtask

    initial begin
        int  cd;
        bit  prev_busy;

        rstn     = 1'b0;
        div_done = 1'b0;
        drive(1'b1, U_ADD, 6'd5);
        tick();
        #3;
        chk("rst_comb", 32'({req_ready, add_go, mul_go, half_go, div_go, mul_half, div_ack}),
            32'd0);
        chk("rst_wb", wbv(), 32'd0);
        tick();
        rstn = 1'b1;

        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1'b1, U_ADD, 6'd5);
            else drive(1'b0, U_ADD, '0);
            #3;
            if (k == 0) chk("rel_accept", 32'({req_ready, add_go}), 32'b11);
            if (k == 2) chk("rel_no_wb_early", 32'(wb_valid), 32'd0);
            if (k == 3) chk("rel_wb", wbv(), 32'({1'b1, U_ADD, 6'd5}));
            tick();
        end
        idle(4);

        for (int k = 0; k < 6; k++) begin
            drive(1'b0, U_ADD, '0);
            if (k == 0) drive(1'b1, U_ADD, 6'd1);
            if (k == ColGap || k == ColGap + 1) drive(1'b1, ColOp, 6'd2);
            #3;
            if (k == 0) chk("col_first", 32'(req_ready), 32'd1);
            if (k == ColGap) chk("col_stall", 32'(req_ready), 32'd0);
            if (k == ColGap + 1) chk("col_retry", 32'(req_ready), 32'd1);
            if (k == 3) chk("col_wb1", wbv(), 32'({1'b1, U_ADD, 6'd1}));
            if (k == 4) chk("col_wb2", wbv(), 32'({1'b1, ColOp, 6'd2}));
            tick();
        end
        idle(4);

        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1'b1, U_MUL, TW'(3 + k));
            else drive(1'b0, U_ADD, '0);
            #3;
            if (k < 3) chk("b2b_ready", 32'({req_ready, mul_go}), 32'b11);
            if (k >= 2) chk("b2b_wb", wbv(), 32'({1'b1, U_MUL, TW'(1 + k)}));
            tick();
        end
        idle(4);

        for (int k = 0; k < 10; k++) begin
            drive(1'b0, U_ADD, '0);
            div_done = (k == 4 || k == 5 || k == 8);
            case (k)
                0: drive(1'b1, U_DIV, 6'd9);
                1: drive(1'b1, U_DIV, 6'd10);
                2: drive(1'b1, U_ADD, 6'd7);
                5, 6: drive(1'b1, U_DIV, 6'd11);
                8: drive(1'b1, PriOp, 6'd12);
`ifdef FPU_SCHED_FHALF_EN
                9: drive(1'b1, PriOp, 6'd12);
`endif
                default: ;
            endcase
            #3;
            case (k)
                0: chk("div_accept", 32'({req_ready, div_go}), 32'b11);
                1: chk("div_second_stall", 32'(req_ready), 32'd0);
                2: chk("div_add_issue", 32'(req_ready), 32'd1);
                4: chk("div_no_ack_slot_busy", 32'(div_ack), 32'd0);
                5: begin
                    chk("div_ack", 32'({div_ack, req_ready}), 32'b10);
                    chk("div_wb_add_first", wbv(), 32'({1'b1, U_ADD, 6'd7}));
                end
                6: begin
                    chk("div_wb", wbv(), 32'({1'b1, U_DIV, 6'd9}));
                    chk("div_idle_again", 32'(req_ready), 32'd1);
                end
                8: chk("claim_priority", 32'({div_ack, req_ready}), 32'({1'b1, PriRdy}));
                9: chk("claim_wb", wbv(), 32'({1'b1, U_DIV, 6'd11}));
                default: ;
            endcase
            tick();
        end
        div_done = 1'b0;
        idle(4);

        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1'b1, U_HALF, 6'd6);
            else drive(1'b0, U_ADD, '0);
            #3;
            if (k == 0) chk("half_strobes", 32'({mul_go, mul_half, half_go}), 32'(HalfGo));
            if (k == HalfLat) chk("half_wb", wbv(), 32'({1'b1, HalfSel, 6'd6}));
            tick();
        end
        idle(4);

        cd        = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) < 7) drive(1'b1, fpu_unit_t'($urandom_range(0, 3)),
                                                TW'($urandom));
            else drive(1'b0, U_ADD, '0);
            if (m_div_busy) begin
                if (!prev_busy) cd = $urandom_range(0, 5);
                if (cd > 0) begin
                    cd--;
                    div_done = 1'b0;
                end else begin
                    div_done = 1'b1;
                end
            end else begin
                div_done = ($urandom_range(0, 9) == 0);
            end
            prev_busy = m_div_busy;
            tick();
        end
        rstn     = 1'b1;
        div_done = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_sched.md
# fpu_sched

Issue scheduler for the FPU cluster. It accepts one floating-point op per cycle from the core's FP issue stage and fires the start strobe of the target unit: pipelined fadd, pipelined fmul, single-cycle fhalf, or iterative fdiv. It reserves the shared writeback port so that no two units ever return a result in the same cycle. It sits between FP issue and the FPU datapath units. The result mux and the FP register-file write port are driven from its writeback outputs.

## Interface
Parameters:
- TAG_W, 6, width of destination/ROB tag carried with each op
- LAT_ADD, 3, issue-to-writeback cycles for fadd/fsub
- LAT_MUL, 2, issue-to-writeback cycles for fmul
- LAT_HALF, 1, issue-to-writeback cycles for fhalf

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  op offered
- req_ready  out  1  op accepted this cycle (combinational)
- req_op  in  2  fpu_unit_t: U_ADD, U_MUL, U_HALF, U_DIV
- req_tag  in  TAG_W  tag of the op
- add_go / mul_go / half_go / div_go  out  1 each  one-cycle start strobe to the unit, asserted in the accept cycle
- mul_half  out  1  with mul_go: operand-B mux selects constant 0.5 (only without FPU_SCHED_FHALF_EN)
- div_done  in  1  fdiv result valid; held until div_ack
- div_ack  out  1  fdiv result claimed
- wb_valid  out  1  write FP register file this cycle (registered)
- wb_sel  out  2  fpu_unit_t selecting the result mux
- wb_tag  out  TAG_W  tag being written back

## Operation
- Reservation ring: slots 1..MAXLAT, where MAXLAT = max of the three latencies. Each slot holds {valid, unit, tag}. It shifts toward slot 1 every cycle. Slot 1 loads the wb_* registers.
- Accept (fixed unit, latency L): req_ready=1 iff slot L is empty after this cycle's shift AND, when L=1, no div claim is happening this cycle. On accept, write {1, op, tag} into slot L and pulse the unit's go.
- Accept (U_DIV): req_ready=1 iff div FSM is IDLE. On accept, pulse div_go and latch req_tag into div_tag.
- Div FSM:
  - IDLE → RUN on accept.
  - RUN → IDLE on claim.
  - Claim happens when div_done=1 and the slot that will write back next cycle is empty. The claim pulses div_ack and forces the next wb to {1, U_DIV, div_tag}.
  - A claim beats a same-cycle LAT=1 issue, so a waiting div result is never starved.
- Ops are accepted in order but complete out of order; tags identify results. Hazard checking is not this block's job.
- Unknown op encodings cannot occur (2-bit enum is complete).
- Without req_valid, all go strobes stay low and nothing is reserved.

## Timing
- Accept at cycle t → wb_valid at t+LAT_ADD / t+LAT_MUL / t+LAT_HALF.
- Div claim at cycle t → wb_valid at t+1.
- Peak throughput: 1 op/cycle when latencies do not collide.
  - Example: ADD at t then HALF at t+2 collide at t+3; HALF is stalled 1 cycle.
- Reset (rstn=0 at an edge): all slots invalid, FSM IDLE, and wb_valid, wb_sel, wb_tag, div_ack and every go set to 0.
  - Reset mid-operation drops every in-flight reservation. The fdiv unit shares rstn and abandons its work.
- div_done while FSM is IDLE is ignored (no ack).
- A second U_DIV while RUN sees req_ready=0 until the claim cycle has passed (FSM back to IDLE).

## Configuration
- FPU_SCHED_FHALF_EN defined:
  - U_HALF issues to half_go with LAT_HALF.
  - mul_half is constant 0.
- FPU_SCHED_FHALF_EN undefined:
  - U_HALF issues as fmul with mul_go=1 and mul_half=1, using LAT_MUL.
  - wb_sel reports U_MUL.
  - half_go is tied 0.

## Structure
- fpu_pkg: fpu_unit_t enum, the default LAT_* localparams, and the res_slot_t struct {valid, unit, tag}.
- One sub-module, fpu_wb_ring: the reservation shift ring with a per-slot occupancy query port. The div FSM and accept logic stay in fpu_sched.

## Test plan
- Reset: rstn=0 for 2 cycles with req_valid=1 → all outputs 0; first cycle after release accepts ADD tag 5 → wb_valid with wb_sel=U_ADD, wb_tag=5 exactly 3 cycles later.
- Collision: ADD tag 1 at t, then HALF tag 2 offered at t+2 → req_ready=0 at t+2. HALF accepted t+3 → wb tag 1 at t+3, tag 2 at t+4.
- Back-to-back: MUL tags 3,4,5 on consecutive cycles → all accepted; wb tags 3,4,5 on three consecutive cycles.
- Div:
  - DIV tag 9 accepted; second DIV stalled while RUN.
  - div_done raised in a cycle where slot 1 holds ADD tag 7 → no ack; wb tag 7 first.
  - Ack the next cycle → wb U_DIV tag 9 one cycle later.
- Claim priority: div_done=1 with slot 1 free and HALF offered the same cycle → div_ack=1, req_ready=0; HALF accepted next cycle.
- Config off (FPU_SCHED_FHALF_EN undefined): HALF tag 6 → mul_go=1, mul_half=1, half_go=0; wb_sel=U_MUL, tag 6 at t+2.
